// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared types and default sizes for the binary-search block
//
// Purpose: state encoding of the search FSM and the default element/address
// widths used by bs_generic and bs_generic_ctrl.
// Ports: none (package).
package bs_pkg;

  localparam int BS_DATA_W = 8;
  localparam int BS_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } bs_state_e;

endpackage

// File: rtl/bs_generic_ctrl.sv
// rtl/bs_generic_ctrl.sv - search sequencing FSM (IDLE/ISSUE/CMP/DONE)
//
// Purpose: steps the binary search through address issue and compare cycles,
// and parks in DONE until the requester drops start.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start_i     - level search request
//   stop_i      - datapath verdict in CMP: search is finished
//   state_o     - current FSM state, decoded by the datapath
//   busy_o      - high in ISSUE and CMP
//   done_o      - high in DONE
module bs_generic_ctrl
  import bs_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      start_i,
  input  logic      stop_i,
  output bs_state_e state_o,
  output logic      busy_o,
  output logic      done_o
);

  bs_state_e state_q;
  bs_state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   state_d = CMP;
      CMP:     state_d = stop_i ? DONE : ISSUE;
      // A held start must not retrigger; only a fresh request in IDLE does.
      DONE:    if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign busy_o  = (state_q == ISSUE) || (state_q == CMP);
  assign done_o  = (state_q == DONE);

endmodule

// File: rtl/bs_generic.sv
// rtl/bs_generic.sv - binary search over an external synchronous RAM
//
// Purpose: exact-match or lower-bound search of a non-decreasing RAM image.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   start       - level request, sampled in IDLE
//   lower_bound - 0: exact match, 1: first index with mem >= A
//   A           - search key
//   mem_addr    - registered RAM read address
//   mem_rdata   - RAM data, valid one cycle after mem_addr
//   busy        - search in progress
//   done        - result available
//   found       - result flag
//   result_addr - result index
module bs_generic
  import bs_pkg::*;
#(
  parameter int DATA_W = BS_DATA_W,
  parameter int ADDR_W = BS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lower_bound,
  input  logic [DATA_W-1:0] A,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr
);

  // Pointers carry one extra bit so lo can step past DEPTH-1 and lo+hi fits.
  localparam logic [ADDR_W:0] PTR_ZERO = '0;
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_MAX  = {1'b0, {ADDR_W{1'b1}}};

  bs_state_e state;
  logic      stop;

  logic [DATA_W-1:0] key_q, key_d;
  logic              mode_q, mode_d;
  logic [ADDR_W:0]   lo_q, lo_d;
  logic [ADDR_W:0]   hi_q, hi_d;
  logic [ADDR_W:0]   mid_q, mid_d;
  logic [ADDR_W:0]   sum_d;
  logic [ADDR_W-1:0] cand_q, cand_d;
  logic              cand_valid_q, cand_valid_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] result_q, result_d;
  logic              term;

  bs_generic_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .stop_i  (stop),
    .state_o (state),
    .busy_o  (busy),
    .done_o  (done)
  );

  always_comb begin
    key_d        = key_q;
    mode_d       = mode_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    mid_d        = mid_q;
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
    found_d      = found_q;
    result_d     = result_q;
    stop         = 1'b0;
    term         = 1'b0;
    sum_d        = '0;

    case (state)
      IDLE: begin
        if (start) begin
          key_d        = A;
          mode_d       = lower_bound;
          lo_d         = PTR_ZERO;
          hi_d         = PTR_MAX;
          cand_d       = '0;
          cand_valid_d = 1'b0;
          found_d      = 1'b0;
          result_d     = '0;
        end
      end
      CMP: begin
        if (!mode_q && (mem_rdata == key_q)) begin
          found_d  = 1'b1;
          result_d = mid_q[ADDR_W-1:0];
          stop     = 1'b1;
        end else if (mem_rdata < key_q) begin
          lo_d = mid_q + PTR_ONE;
          term = (lo_d > hi_q);
        end else begin
          if (mode_q) begin
            cand_d       = mid_q[ADDR_W-1:0];
            cand_valid_d = 1'b1;
          end
          // Moving down from index 0 would wrap hi; the search is exhausted.
          if (mid_q == PTR_ZERO) begin
            term = 1'b1;
          end else begin
            hi_d = mid_q - PTR_ONE;
            term = (lo_q > hi_d);
          end
        end
        if (term) begin
          stop     = 1'b1;
          found_d  = mode_q & cand_valid_d;
          result_d = (mode_q && cand_valid_d) ? cand_d : '0;
        end
      end
      default: ;
    endcase

    // The probe address is registered on the edge entering ISSUE, so the RAM
    // samples it at the end of ISSUE and returns data during CMP.
    if ((state == IDLE && start) || (state == CMP && !stop)) begin
      sum_d = lo_d + hi_d;
      mid_d = sum_d >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q        <= '0;
      mode_q       <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      mid_q        <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      found_q      <= 1'b0;
      result_q     <= '0;
    end else begin
      key_q        <= key_d;
      mode_q       <= mode_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      mid_q        <= mid_d;
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      found_q      <= found_d;
      result_q     <= result_d;
    end
  end

  assign mem_addr    = mid_q[ADDR_W-1:0];
  assign found       = found_q;
  assign result_addr = result_q;

endmodule

// File: tb/tb_bs_generic.sv
// tb/tb_bs_generic.sv - scoreboard bench for bs_generic over a 2*i RAM image
module tb_bs_generic;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       lower_bound;
  logic [7:0] A;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] result_addr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       f;
    logic [4:0] a;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic       lb;
    logic       ef;
    logic [4:0] ea;
    int         hold;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  logic [7:0] mem [0:31];
  vec_t vecs [0:9];

  bs_generic #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lower_bound (lower_bound),
    .A           (A),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .result_addr (result_addr)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
  end

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: every rising done consumes one expectation.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, want no result pending");
      end else begin
        mon_e = exp_q.pop_front();
        chk("found", int'(found), int'(mon_e.f));
        chk("result_addr", int'(result_addr), int'(mon_e.a));
      end
    end
    done_prev = done;
  end

  task automatic run(input logic [7:0] a, input logic lb, input logic ef,
                     input logic [4:0] ea, input int hold);
    int lat;
    @(negedge clk);
    A = a;
    lower_bound = lb;
    start = 1'b1;
    exp_q.push_back('{f: ef, a: ea});
    @(negedge clk);
    lat = 0;
    chk("busy_after_start", int'(busy), 1);
    // Key and mode changes mid-search must be ignored.
    A = ~a;
    lower_bound = ~lb;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got no done after %0d cycles, want done", lat);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      chk("latency_le_13", int'(lat <= 13), 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_busy", int'(busy), 0);
      chk("hold_found", int'(found), int'(ef));
      chk("hold_result", int'(result_addr), int'(ea));
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_found", int'(found), int'(ef));
    chk("idle_result", int'(result_addr), int'(ea));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{a: 8'h10, lb: 1'b0, ef: 1'b1, ea: 5'd8,  hold: 30};
    vecs[1] = '{a: 8'h00, lb: 1'b0, ef: 1'b1, ea: 5'd0,  hold: 0};
    vecs[2] = '{a: 8'h3E, lb: 1'b0, ef: 1'b1, ea: 5'd31, hold: 0};
    vecs[3] = '{a: 8'h11, lb: 1'b0, ef: 1'b0, ea: 5'd0,  hold: 0};
    vecs[4] = '{a: 8'h11, lb: 1'b1, ef: 1'b1, ea: 5'd9,  hold: 0};
    vecs[5] = '{a: 8'h00, lb: 1'b1, ef: 1'b1, ea: 5'd0,  hold: 0};
    vecs[6] = '{a: 8'h40, lb: 1'b1, ef: 1'b0, ea: 5'd0,  hold: 0};
    vecs[7] = '{a: 8'h10, lb: 1'b1, ef: 1'b1, ea: 5'd8,  hold: 0};
    vecs[8] = '{a: 8'hFF, lb: 1'b0, ef: 1'b0, ea: 5'd0,  hold: 0};
    vecs[9] = '{a: 8'h3D, lb: 1'b1, ef: 1'b1, ea: 5'd31, hold: 2};

    reset = 1'b1;
    start = 1'b0;
    lower_bound = 1'b0;
    A = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_result", int'(result_addr), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    foreach (vecs[i]) run(vecs[i].a, vecs[i].lb, vecs[i].ef, vecs[i].ea, vecs[i].hold);

    // Reset during the third cycle of a search.
    @(negedge clk);
    A = 8'h20;
    lower_bound = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_found", int'(found), 0);
    chk("midrst_result", int'(result_addr), 0);
    chk("midrst_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_stay_idle", int'(busy | done), 0);
    end
    run(8'h10, 1'b0, 1'b1, 5'd8, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bs_generic.md
BS_GENERIC -- requirements
Module: bs_generic

Interface
REQ-001 Parameter DATA_W, default 8, sets the width of searched elements and of the key.
REQ-002 Parameter ADDR_W, default 5, sets the memory depth DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level request; a search begins when start=1 in IDLE.
REQ-006 lower_bound  input  1  mode select: 0 = exact match, 1 = first index with mem >= A; sampled with start.
REQ-007 A  input  DATA_W  search key; sampled with start.
REQ-008 mem_addr  output  ADDR_W  read address to an external synchronous RAM.
REQ-009 mem_rdata  input  DATA_W  RAM read data; valid one cycle after mem_addr is presented.
REQ-010 busy  output  1  high while a search is in progress.
REQ-011 done  output  1  high while in DONE.
REQ-012 found  output  1  search result flag; valid while done=1.
REQ-013 result_addr  output  ADDR_W  result index; valid while done=1.

Function
REQ-014 The block SHALL implement the FSM states IDLE, ISSUE, CMP and DONE.
REQ-015 IDLE SHALL go to ISSUE when start=1, capturing A and lower_bound, and setting lo=0, hi=DEPTH-1 and cand_valid=0.
REQ-016 lo and hi SHALL be ADDR_W+1 bits wide; mid SHALL equal (lo+hi)>>1, computed in ADDR_W+1 bits with no overflow.
REQ-017 In ISSUE, mem_addr SHALL equal mid[ADDR_W-1:0] (registered); the next state SHALL be CMP.
REQ-018 In CMP with mem_rdata==A and lower_bound=0, the block SHALL set found=1 and result_addr=mid, then go to DONE.
REQ-019 In CMP with mem_rdata<A, the block SHALL set lo=mid+1.
REQ-020 In CMP with mem_rdata>A, or with mem_rdata>=A in lower-bound mode, the block SHALL record cand=mid and set cand_valid=1 (lower-bound mode only), then set hi=mid-1.
REQ-021 When mid=0 and the search moves down, the block SHALL terminate rather than underflow hi.
REQ-022 After a CMP update, the block SHALL go to DONE if lo>hi (or on REQ-021 termination); otherwise it SHALL go to ISSUE.
REQ-023 On termination in exact mode, the block SHALL set found=0 and result_addr=0.
REQ-024 On termination in lower-bound mode, the block SHALL set found=cand_valid, result_addr=cand if cand_valid, else 0.
REQ-025 DONE SHALL hold found and result_addr stable until start=0, then go to IDLE; start held high SHALL NOT restart a search.
REQ-026 In IDLE, found and result_addr SHALL retain the last result; they SHALL be cleared on entry to ISSUE from IDLE.
REQ-027 Latency from the start-sampling edge to done=1 SHALL NOT exceed 2*(ADDR_W+1)+1 cycles; each probe SHALL take exactly 2 cycles.
REQ-028 busy SHALL equal 1 exactly in ISSUE and CMP.
REQ-029 Changes to A or lower_bound during a search SHALL have no effect.
REQ-030 Correct results SHALL be guaranteed only for non-decreasing RAM contents; duplicate keys in exact mode may return any matching index.

Reset
REQ-031 On reset=1 at a clock edge, from any state including mid-search, the FSM SHALL go to IDLE.
REQ-032 On that reset, busy, done, found, result_addr and mem_addr SHALL all be 0.
REQ-033 On that reset, lo, hi, cand and cand_valid SHALL be cleared.
REQ-034 After reset is released, a search SHALL start only on a fresh start=1 in IDLE.

Structure
REQ-035 A shared package bs_pkg SHALL hold the state enum typedef (IDLE, ISSUE, CMP, DONE) and the default DATA_W/ADDR_W constants.
REQ-036 The RAM SHALL be external to the block.
REQ-037 The only sub-module SHALL be bs_generic_ctrl (FSM), with the lo/hi/mid/cand datapath in bs_generic.

Verification
Bench setup: DATA_W=8, ADDR_W=5, synchronous RAM model with 1-cycle read latency, mem[i]=2*i (0..62).
REQ-038 Exact mode, A=8'h10, start=1 -> done=1 within 13 cycles, found=1, result_addr=8.
REQ-039 Exact mode, A=8'h00 and A=8'h3E -> found=1 with result_addr=0 and 31 respectively.
REQ-040 Exact mode, A=8'h11 -> found=0, result_addr=0.
REQ-041 Lower-bound mode: A=8'h11 -> found=1, result_addr=9; A=8'h00 -> found=1, result_addr=0; A=8'h40 -> found=0, result_addr=0.
REQ-042 start held high for 30 cycles after done -> exactly one search, outputs stable; start=0 -> IDLE, result held.
REQ-043 reset=1 in the third cycle of a search -> next cycle all outputs 0 and state IDLE; a new start with A=8'h10 -> result_addr=8.
